result_bcd_converter: RTL and testbench

Sequential binary-to-BCD converter that answers the control unit's `conversion_en` request and returns `conversion_ready`. It sits in the display path between `arithmetic_unit` and the seven-segment driver. It is the reverse of the BCD-to-binary packing done on button entry: it turns the 32-bit `result` into ten BCD digits, a sign flag and a significant-digit count, using iterative shift-add-3 (double dabble).

---
 rtl/result_bcd_converter.sv | 142 ++++++++++++++
 tb/tb_result_bcd_converter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/result_bcd_converter.sv
// Iterative double-dabble converter: 32-bit result -> ten BCD digits, sign and digit count.
// Optional macro BCD_SIGNED_EN treats result_in as two's complement.
module result_bcd_converter #(
  parameter int WIDTH = 32
) (
  input  logic             CLK100MHz,
  input  logic             reset,
  input  logic [WIDTH-1:0] result_in,
  input  logic             conversion_en,
  output logic             conversion_ready,
  output logic [39:0]      bcd_out,
  output logic             sign_out,
  output logic [3:0]       num_digits
);

  localparam int DIGITS = 10;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] bin_q, bin_d;
  logic [39:0] scr_q, scr_d;
  logic        neg_q, neg_d;
  logic [39:0] bcd_q, bcd_d;
  logic        sign_q, sign_d;
  logic [3:0]  ndig_q, ndig_d;
  logic        rdy_q, rdy_d;

  logic [39:0] scr_adj;
  logic [39:0] scr_next;
  logic        in_neg;
  logic [31:0] in_mag;

  function automatic logic [39:0] add3_all(input logic [39:0] s);
    logic [39:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [3:0] count_digits(input logic [39:0] s);
    logic [3:0] n;
    n = 4'd1;
    for (int i = 0; i < DIGITS; i++) begin
      if (s[4*i +: 4] != 4'd0) n = 4'(i + 1);
    end
    return n;
  endfunction

`ifdef BCD_SIGNED_EN
  // Negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude.
  assign in_neg = result_in[31];
  assign in_mag = in_neg ? (~result_in[31:0] + 32'd1) : result_in[31:0];
`else
  assign in_neg = 1'b0;
  assign in_mag = result_in[31:0];
`endif

  assign scr_adj  = add3_all(scr_q);
  assign scr_next = {scr_adj[38:0], bin_q[31]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    neg_d   = neg_q;
    bcd_d   = bcd_q;
    sign_d  = sign_q;
    ndig_d  = ndig_q;
    rdy_d   = rdy_q;
    case (state_q)
      IDLE: begin
        rdy_d = 1'b0;
        if (conversion_en) begin
          bin_d   = in_mag;
          neg_d   = in_neg;
          scr_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!conversion_en) begin
          state_d = IDLE;
        end else begin
          scr_d = scr_next;
          bin_d = {bin_q[30:0], 1'b0};
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            bcd_d   = scr_next;
            sign_d  = neg_q;
            ndig_d  = count_digits(scr_next);
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (conversion_en) begin
          rdy_d = 1'b1;
        end else begin
          rdy_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHz) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      scr_q   <= '0;
      neg_q   <= 1'b0;
      bcd_q   <= '0;
      sign_q  <= 1'b0;
      ndig_q  <= 4'd1;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      neg_q   <= neg_d;
      bcd_q   <= bcd_d;
      sign_q  <= sign_d;
      ndig_q  <= ndig_d;
      rdy_q   <= rdy_d;
    end
  end

  assign conversion_ready = rdy_q;
  assign bcd_out          = bcd_q;
  assign sign_out         = sign_q;
  assign num_digits       = ndig_q;

endmodule

// File: tb/tb_result_bcd_converter.sv
// Scoreboard bench for result_bcd_converter: decimal reference model, random and directed requests.
module tb_result_bcd_converter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] result_in;
  logic        conversion_en;
  logic        conversion_ready;
  logic [39:0] bcd_out;
  logic        sign_out;
  logic [3:0]  num_digits;

  result_bcd_converter #(.WIDTH(32)) dut (
    .CLK100MHz       (clk),
    .reset           (reset),
    .result_in       (result_in),
    .conversion_en   (conversion_en),
    .conversion_ready(conversion_ready),
    .bcd_out         (bcd_out),
    .sign_out        (sign_out),
    .num_digits      (num_digits)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [39:0] b;
    logic        s;
    logic [3:0]  nd;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal expansion by repeated division, independent of any shift-add scheme.
  function automatic exp_t model(input logic [31:0] v);
    exp_t        e;
    longint      m;
`ifdef BCD_SIGNED_EN
    e.s = v[31];
    m   = v[31] ? (64'sd4294967296 - longint'({32'd0, v})) : longint'({32'd0, v});
`else
    e.s = 1'b0;
    m   = longint'({32'd0, v});
`endif
    e.b  = '0;
    e.nd = 4'd1;
    for (int i = 0; i < 10; i++) begin
      e.b[4*i +: 4] = 4'(m % 10);
      if ((m % 10) != 0) e.nd = 4'(i + 1);
      m = m / 10;
    end
    return e;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check_held(input string tag);
    check({tag, "_bcd"}, 64'(bcd_out), 64'(last.b));
    check({tag, "_sign"}, 64'(sign_out), 64'(last.s));
    check({tag, "_nd"}, 64'(num_digits), 64'(last.nd));
  endtask

  // Monitor: compare on each rising edge of conversion_ready.
  logic rdy_prev = 1'b0;
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (conversion_ready && !rdy_prev) begin
      if (q.size() == 0) begin
        check("mon_unexpected_ready", 64'(conversion_ready), 64'd0);
      end else begin
        e = q.pop_front();
        check("mon_bcd", 64'(bcd_out), 64'(e.b));
        check("mon_sign", 64'(sign_out), 64'(e.s));
        check("mon_ndig", 64'(num_digits), 64'(e.nd));
      end
    end
    rdy_prev = conversion_ready;
  end

  // Full conversion; optionally corrupt result_in mid-way to show it is ignored.
  task automatic run_conv(input logic [31:0] v, input logic [31:0] late_v, input int hold);
    int n;
    result_in     = v;
    conversion_en = 1'b1;
    step;
    q.push_back(model(v));
    last = model(v);
    n = 0;
    while (!conversion_ready && n < 40) begin
      step;
      n++;
      if (n == 5) result_in = late_v;
    end
    check("latency", 64'(n), 64'd33);
    repeat (hold) step;
    check("ready_held", 64'(conversion_ready), 64'd1);
    conversion_en = 1'b0;
    step;
    check("ready_fall", 64'(conversion_ready), 64'd0);
    check_held("idle_hold");
  endtask

  // Drop en after k iterations: no ready, outputs keep last completed result.
  task automatic run_abort(input logic [31:0] v, input int k);
    int saw;
    saw = 0;
    result_in     = v;
    conversion_en = 1'b1;
    step;
    repeat (k) begin
      step;
      if (conversion_ready) saw++;
    end
    conversion_en = 1'b0;
    repeat (3) begin
      step;
      if (conversion_ready) saw++;
    end
    check("abort_no_ready", 64'(saw), 64'd0);
    check_held("abort_hold");
  endtask

  initial begin
    reset         = 1'b1;
    conversion_en = 1'b0;
    result_in     = '0;
    last.b  = '0;
    last.s  = 1'b0;
    last.nd = 4'd1;
    repeat (3) step;
    check("rst_ready", 64'(conversion_ready), 64'd0);
    check_held("rst");
    reset = 1'b0;
    step;

    run_conv(32'd0, 32'd0, 0);
    run_conv(32'd12345, 32'd999, 2);
    run_conv(32'hFFFF_FFFF, 32'd1, 0);
    run_conv(32'h8000_0000, 32'd7, 1);
    run_conv(32'd12345, 32'd0, 0);
    run_abort(32'd777, 20);
    run_conv(32'd777, 32'd5, 0);

    // Reset at iteration 10 of a conversion.
    result_in     = 32'd987654;
    conversion_en = 1'b1;
    step;
    repeat (10) step;
    reset = 1'b1;
    step;
    last.b  = '0;
    last.s  = 1'b0;
    last.nd = 4'd1;
    check("midrst_ready", 64'(conversion_ready), 64'd0);
    check_held("midrst");
    reset         = 1'b0;
    conversion_en = 1'b0;
    repeat (40) begin
      step;
      if (conversion_ready) check("midrst_no_ready", 64'(conversion_ready), 64'd0);
    end

    for (int i = 0; i < 24; i++) begin
      logic [31:0] v;
      case ($urandom_range(0, 3))
        0:       v = $urandom_range(0, 99);
        1:       v = 32'h8000_0000 ^ ($urandom_range(0, 1));
        default: v = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) run_abort(v, $urandom_range(0, 31));
      else run_conv(v, $urandom, $urandom_range(0, 3));
    end

    repeat (3) step;
    check("queue_empty", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
